// File: rtl/axi_regs_arbiter.sv
// axi_regs_arbiter: shares a simple-dual-port register memory between the AXI
// register path (bram_* side) and an internal host-controller requester.
// AXI always wins a port; the internal requester takes idle port cycles and,
// if it is kept waiting too long, withdraws the matching AXI dev_ready.
module axi_regs_arbiter #(
    parameter int unsigned ADDRESS_BITS = 8,
    parameter int unsigned MAX_WAIT     = 16
) (
    input  logic                    aclk,
    input  logic                    arst,
    // AXI-side register path
    input  logic [ADDRESS_BITS-1:0] bram_waddr,
    input  logic [31:0]             bram_wdata,
    input  logic [3:0]              bram_wstb,
    input  logic                    bram_wen,
    input  logic [ADDRESS_BITS-1:0] bram_raddr,
    input  logic                    bram_ren,
    input  logic                    bram_regen,
    output logic [31:0]             bram_rdata,
    output logic                    axi_wr_dev_ready,
    output logic                    axi_rd_dev_ready,
    // Internal requester
    input  logic                    int_req,
    input  logic                    int_we,
    input  logic [ADDRESS_BITS-1:0] int_addr,
    input  logic [31:0]             int_wdata,
    output logic                    int_ack,
    output logic [31:0]             int_rdata,
    // Register memory
    output logic                    mem_we,
    output logic [ADDRESS_BITS-1:0] mem_waddr,
    output logic [31:0]             mem_wdata,
    output logic [3:0]              mem_wstb,
    output logic                    mem_ren,
    output logic [ADDRESS_BITS-1:0] mem_raddr,
    input  logic [31:0]             mem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StRdLat,
        StAck
    } state_e;

    localparam logic [7:0] WaitLimit = 8'(MAX_WAIT);

    state_e     state_q;
    logic [7:0] wait_q;
    logic [7:0] wait_inc;
    logic       wr_issue;
    logic       rd_issue;

    // Internal accesses start only from IDLE, on a cycle the AXI side leaves that port free.
    always_comb begin
        wr_issue = !arst && (state_q == StIdle) && int_req && int_we && !bram_wen;
        rd_issue = !arst && (state_q == StIdle) && int_req && !int_we && !bram_ren;
        wait_inc = (wait_q == 8'hff) ? wait_q : wait_q + 8'd1;
    end

    // Write port mux: AXI passes straight through, internal writes are full-word.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bram_waddr;
        mem_wdata = bram_wdata;
        mem_wstb  = bram_wstb;
        if (bram_wen) begin
            mem_we = 1'b1;
        end else if (wr_issue) begin
            mem_we    = 1'b1;
            mem_waddr = int_addr;
            mem_wdata = int_wdata;
            mem_wstb  = 4'hf;
        end
    end

    // Read port mux: AXI read address has priority.
    always_comb begin
        mem_ren   = bram_ren | rd_issue;
        mem_raddr = bram_ren ? bram_raddr : int_addr;
    end

    // AXI read data register; internal reads never overlap bram_regen, so no sharing.
    always_ff @(posedge aclk) begin
        if (arst) begin
            bram_rdata <= 32'h0;
        end else if (bram_regen) begin
            bram_rdata <= mem_rdata;
        end
    end

    // Internal-request FSM with wait counter and registered dev_ready / ack / read data.
    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q          <= StIdle;
            wait_q           <= 8'h0;
            int_ack          <= 1'b0;
            int_rdata        <= 32'h0;
            axi_wr_dev_ready <= 1'b1;
            axi_rd_dev_ready <= 1'b1;
        end else begin
            int_ack <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (wr_issue) begin
                        state_q          <= StAck;
                        int_ack          <= 1'b1;
                        wait_q           <= 8'h0;
                        axi_wr_dev_ready <= 1'b1;
                    end else if (rd_issue) begin
                        state_q          <= StRdLat;
                        wait_q           <= 8'h0;
                        axi_rd_dev_ready <= 1'b1;
                    end else if (int_req) begin
                        wait_q <= wait_inc;
                        // Starved: stop new AXI bursts in the blocked direction so the port drains.
                        if (wait_inc >= WaitLimit) begin
                            if (int_we) begin
                                axi_wr_dev_ready <= 1'b0;
                            end else begin
                                axi_rd_dev_ready <= 1'b0;
                            end
                        end
                    end else begin
                        wait_q <= 8'h0;
                    end
                end
                StRdLat: begin
                    int_rdata <= mem_rdata;
                    int_ack   <= 1'b1;
                    state_q   <= StAck;
                end
                StAck: begin
                    wait_q  <= 8'h0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_regs_arbiter.sv
// Bench for axi_regs_arbiter: directed cases followed by randomized AXI bursts
// and internal requests, checked by a scoreboard against a word-array model.
module tb_axi_regs_arbiter;

    localparam int unsigned AW = 8;
    localparam int          MW = 6;

    logic          aclk;
    logic          arst;
    logic [AW-1:0] bram_waddr;
    logic [31:0]   bram_wdata;
    logic [3:0]    bram_wstb;
    logic          bram_wen;
    logic [AW-1:0] bram_raddr;
    logic          bram_ren;
    logic          bram_regen;
    logic [31:0]   bram_rdata;
    logic          axi_wr_dev_ready;
    logic          axi_rd_dev_ready;
    logic          int_req;
    logic          int_we;
    logic [AW-1:0] int_addr;
    logic [31:0]   int_wdata;
    logic          int_ack;
    logic [31:0]   int_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstb;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;

    axi_regs_arbiter #(
        .ADDRESS_BITS(AW),
        .MAX_WAIT    (MW)
    ) dut (
        .aclk            (aclk),
        .arst            (arst),
        .bram_waddr      (bram_waddr),
        .bram_wdata      (bram_wdata),
        .bram_wstb       (bram_wstb),
        .bram_wen        (bram_wen),
        .bram_raddr      (bram_raddr),
        .bram_ren        (bram_ren),
        .bram_regen      (bram_regen),
        .bram_rdata      (bram_rdata),
        .axi_wr_dev_ready(axi_wr_dev_ready),
        .axi_rd_dev_ready(axi_rd_dev_ready),
        .int_req         (int_req),
        .int_we          (int_we),
        .int_addr        (int_addr),
        .int_wdata       (int_wdata),
        .int_ack         (int_ack),
        .int_rdata       (int_rdata),
        .mem_we          (mem_we),
        .mem_waddr       (mem_waddr),
        .mem_wdata       (mem_wdata),
        .mem_wstb        (mem_wstb),
        .mem_ren         (mem_ren),
        .mem_raddr       (mem_raddr),
        .mem_rdata       (mem_rdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // AXI output register enable trails the read enable by one cycle.
    always @(posedge aclk) begin
        if (arst) bram_regen <= 1'b0;
        else      bram_regen <= bram_ren;
    end

    // Register memory: 1-cycle read latency, read-before-write, byte strobes.
    logic [31:0] mem_model [256];
    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
        mem_rdata <= 32'h0;
        forever begin
            @(posedge aclk);
            if (mem_ren) mem_rdata <= mem_model[mem_raddr];
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstb[b]) mem_model[mem_waddr][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reference contents as seen by the requesters (what a read should return).
    logic [31:0] ref_mem [256];

    typedef struct {
        logic        we;
        logic [31:0] rdata;
    } int_exp_t;

    int_exp_t    int_q[$];
    logic [31:0] axi_q[$];
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] stb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (stb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // Scoreboard monitor: pops an expectation whenever the DUT presents read data or an ack.
    initial begin : monitor
        logic     regen_prev;
        int_exp_t e;
        regen_prev = 1'b0;
        forever begin
            @(negedge aclk);
            if (regen_prev) begin
                if (axi_q.size() == 0) chk("axi_rd_unexpected", 32'd1, 32'd0);
                else                   chk("axi_rdata", bram_rdata, axi_q.pop_front());
            end
            regen_prev = bram_regen && !arst;
            if (int_ack) begin
                if (int_q.size() == 0) begin
                    chk("int_ack_unexpected", 32'd1, 32'd0);
                end else begin
                    e = int_q.pop_front();
                    if (!e.we) chk("int_rdata", int_rdata, e.rdata);
                end
            end
        end
    end

    task automatic int_issue(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                             input bit push);
        int_exp_t e;
        if (push) begin
            e.we    = we;
            e.rdata = we ? 32'h0 : ref_mem[addr];
            if (we) ref_mem[addr] = data;
            int_q.push_back(e);
        end
        int_we    = we;
        int_addr  = addr;
        int_wdata = data;
        int_req   = 1'b1;
    endtask

    task automatic int_drop;
        @(posedge aclk);
        #1;
        int_req = 1'b0;
    endtask

    task automatic int_op(input logic we, input logic [AW-1:0] addr, input logic [31:0] data,
                          output int lat);
        bit got;
        int_issue(we, addr, data, 1'b1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge aclk);
            lat++;
            got = int_ack;
        end
        if (!got) chk("int_ack_timeout", 32'd0, 32'd1);
        int_drop();
    endtask

    task automatic wait_ready(input bit wr);
        int t;
        t = 0;
        while ((wr ? !axi_wr_dev_ready : !axi_rd_dev_ready) && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300) chk(wr ? "wr_ready_timeout" : "rd_ready_timeout", 32'd0, 32'd1);
    endtask

    // Random AXI write bursts into the upper half; reference updated at the write's clock edge.
    task automatic axi_writer(input int bursts);
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    s;
        for (int n = 0; n < bursts; n++) begin
            wait_ready(1'b1);
            for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
                a = 8'h80 | 8'($urandom_range(0, 127));
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                bram_wen   = 1'b1;
                bram_waddr = a;
                bram_wdata = d;
                bram_wstb  = s;
                @(posedge aclk);
                ref_mem[a] = merge(ref_mem[a], d, s);
                #1;
            end
            bram_wen = 1'b0;
            repeat ($urandom_range(0, 4)) tick();
        end
    endtask

    task automatic axi_reader(input int bursts);
        logic [AW-1:0] a;
        for (int n = 0; n < bursts; n++) begin
            wait_ready(1'b0);
            for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
                a = 8'h80 | 8'($urandom_range(0, 127));
                bram_ren   = 1'b1;
                bram_raddr = a;
                axi_q.push_back(ref_mem[a]);
                tick();
            end
            bram_ren = 1'b0;
            repeat ($urandom_range(0, 4)) tick();
        end
    endtask

    task automatic int_random(input int ops);
        int lat;
        for (int n = 0; n < ops; n++) begin
            int_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), $urandom, lat);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin : main
        int lat;
        bit ok;
        checks     = 0;
        errors     = 0;
        arst       = 1'b1;
        bram_waddr = '0;
        bram_wdata = '0;
        bram_wstb  = '0;
        bram_wen   = 1'b0;
        bram_raddr = '0;
        bram_ren   = 1'b0;
        int_req    = 1'b0;
        int_we     = 1'b0;
        int_addr   = '0;
        int_wdata  = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

        // Reset values
        repeat (3) tick();
        @(negedge aclk);
        chk("rst_int_ack", 32'(int_ack), 32'd0);
        chk("rst_int_rdata", int_rdata, 32'h0);
        chk("rst_bram_rdata", bram_rdata, 32'h0);
        chk("rst_wr_ready", 32'(axi_wr_dev_ready), 32'd1);
        chk("rst_rd_ready", 32'(axi_rd_dev_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        arst = 1'b0;
        tick();

        // Free ports: internal write acks at issue+1, read at issue+2
        int_issue(1'b1, 8'h10, 32'hA5A5_0001, 1'b1);
        @(negedge aclk);
        chk("t1_mem_we", 32'(mem_we), 32'd1);
        chk("t1_mem_wstb", 32'(mem_wstb), 32'hf);
        chk("t1_mem_waddr", 32'(mem_waddr), 32'h10);
        chk("t1_mem_wdata", mem_wdata, 32'hA5A5_0001);
        chk("t1_ack_early", 32'(int_ack), 32'd0);
        @(negedge aclk);
        chk("t1_wr_ack", 32'(int_ack), 32'd1);
        int_drop();
        int_issue(1'b0, 8'h10, 32'h0, 1'b1);
        @(negedge aclk);
        chk("t1_mem_ren", 32'(mem_ren), 32'd1);
        chk("t1_mem_raddr", 32'(mem_raddr), 32'h10);
        @(negedge aclk);
        chk("t1_rd_ack_early", 32'(int_ack), 32'd0);
        @(negedge aclk);
        chk("t1_rd_ack", 32'(int_ack), 32'd1);
        int_drop();

        // AXI write held 5 cycles (< MAX_WAIT) while an internal write waits
        bram_wen   = 1'b1;
        bram_waddr = 8'h42;
        bram_wdata = 32'hBEEF_0042;
        bram_wstb  = 4'hf;
        ref_mem[8'h42] = 32'hBEEF_0042;
        int_issue(1'b1, 8'h41, 32'h5EED_0041, 1'b1);
        ok = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick();
            @(negedge aclk);
            if (mem_waddr != 8'h42 || mem_wdata != 32'hBEEF_0042) ok = 1'b0;
            if (!axi_wr_dev_ready || !axi_rd_dev_ready || int_ack) ok = 1'b0;
        end
        chk("t2_axi_priority_ready", 32'(ok), 32'd1);
        tick();
        bram_wen = 1'b0;
        @(negedge aclk);
        chk("t2_int_waddr", 32'(mem_waddr), 32'h41);
        chk("t2_int_wdata", mem_wdata, 32'h5EED_0041);
        chk("t2_int_wstb", 32'(mem_wstb), 32'hf);
        @(negedge aclk);
        chk("t2_ack", 32'(int_ack), 32'd1);
        chk("t2_wr_ready", 32'(axi_wr_dev_ready), 32'd1);
        int_drop();

        // Continuous AXI reads starve an internal read: rd dev_ready withdrawn after MAX_WAIT
        bram_ren   = 1'b1;
        bram_raddr = 8'h42;
        axi_q.push_back(ref_mem[8'h42]);
        int_issue(1'b0, 8'h10, 32'h0, 1'b1);
        ok = 1'b1;
        for (int k = 1; k <= MW + 2; k++) begin
            if (k > 1) begin
                tick();
                axi_q.push_back(ref_mem[8'h42]);
            end
            @(negedge aclk);
            chk("t3_rd_ready", 32'(axi_rd_dev_ready), (k <= MW) ? 32'd1 : 32'd0);
            if (!axi_wr_dev_ready) ok = 1'b0;
        end
        tick();
        bram_ren = 1'b0;
        @(negedge aclk);
        chk("t3_issue_ren", 32'(mem_ren), 32'd1);
        chk("t3_issue_raddr", 32'(mem_raddr), 32'h10);
        chk("t3_ready_low_at_issue", 32'(axi_rd_dev_ready), 32'd0);
        if (!axi_wr_dev_ready) ok = 1'b0;
        @(negedge aclk);
        chk("t3_ready_back", 32'(axi_rd_dev_ready), 32'd1);
        if (!axi_wr_dev_ready) ok = 1'b0;
        @(negedge aclk);
        chk("t3_ack", 32'(int_ack), 32'd1);
        chk("t3_wr_ready_steady", 32'(ok), 32'd1);
        int_drop();

        // AXI read concurrent with an internal write on the other port
        bram_wen   = 1'b1;
        bram_waddr = 8'h20;
        bram_wdata = 32'h1234_5678;
        bram_wstb  = 4'hf;
        ref_mem[8'h20] = 32'h1234_5678;
        tick();
        bram_wen   = 1'b0;
        bram_ren   = 1'b1;
        bram_raddr = 8'h20;
        axi_q.push_back(ref_mem[8'h20]);
        int_issue(1'b1, 8'h30, 32'hCAFE_0030, 1'b1);
        @(negedge aclk);
        chk("t4_mem_we", 32'(mem_we), 32'd1);
        chk("t4_mem_waddr", 32'(mem_waddr), 32'h30);
        chk("t4_mem_raddr", 32'(mem_raddr), 32'h20);
        tick();
        bram_ren = 1'b0;
        @(negedge aclk);
        chk("t4_ack", 32'(int_ack), 32'd1);
        int_drop();
        chk("t4_mem30", mem_model[8'h30], 32'hCAFE_0030);

        // Same-cycle AXI and internal write to one address: AXI first, internal data final
        bram_wen   = 1'b1;
        bram_waddr = 8'h05;
        bram_wdata = 32'h1111_1111;
        bram_wstb  = 4'hf;
        ref_mem[8'h05] = 32'h1111_1111;
        int_issue(1'b1, 8'h05, 32'h2222_2222, 1'b1);
        @(negedge aclk);
        chk("t5_axi_first", mem_wdata, 32'h1111_1111);
        tick();
        bram_wen = 1'b0;
        @(negedge aclk);
        chk("t5_int_second_we", 32'(mem_we), 32'd1);
        chk("t5_int_second", mem_wdata, 32'h2222_2222);
        @(negedge aclk);
        chk("t5_ack", 32'(int_ack), 32'd1);
        int_drop();
        int_op(1'b0, 8'h05, 32'h0, lat);
        chk("t5_rd_latency", 32'(lat), 32'd3);
        chk("t5_mem05", mem_model[8'h05], 32'h2222_2222);

        // Reset during RD_LAT: no ack, reset values, re-request completes
        int_issue(1'b0, 8'h10, 32'h0, 1'b0);
        @(negedge aclk);
        tick();
        arst = 1'b1;
        @(negedge aclk);
        chk("t6_no_ack_rdlat", 32'(int_ack), 32'd0);
        tick();
        @(negedge aclk);
        chk("t6_rst_ack", 32'(int_ack), 32'd0);
        chk("t6_rst_rdata", int_rdata, 32'h0);
        chk("t6_rst_bram_rdata", bram_rdata, 32'h0);
        chk("t6_rst_ready", 32'({axi_wr_dev_ready, axi_rd_dev_ready}), 32'd3);
        chk("t6_no_issue_in_rst", 32'(mem_ren), 32'd0);
        tick();
        arst    = 1'b0;
        int_req = 1'b0;
        repeat (2) tick();
        int_op(1'b0, 8'h10, 32'h0, lat);
        chk("t6_rereq_latency", 32'(lat), 32'd3);
        int_op(1'b1, 8'h11, 32'h0BAD_F00D, lat);
        chk("t6_wr_latency", 32'(lat), 32'd2);

        // Randomized traffic on both AXI directions plus the internal requester
        fork
            axi_writer(40);
            axi_reader(40);
            int_random(60);
        join
        repeat (6) tick();
        chk("int_q_drained", 32'(int_q.size()), 32'd0);
        chk("axi_q_drained", 32'(axi_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
